// File: rtl/mult_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit encoding and the iteration count derived from the operand width.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_e;

    // Operands are extended by two bits, so WIDTH+2 multiplier bits give WIDTH/2+1 digits.
    function automatic int iter_f(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps the multiplier triplet {b[2i+1], b[2i], b[2i-1]}
// to one of the digits 0, +-1, +-2 (purely combinational).
module booth_r4_enc
    import mult_pkg::*;
(
    input  logic [2:0] trip_i,
    output digit_e     digit_o
);

    always_comb begin
        digit_o = ZERO;
        unique case (trip_i)
            3'b000, 3'b111: digit_o = ZERO;
            3'b001, 3'b010: digit_o = POS1;
            3'b011:         digit_o = POS2;
            3'b100:         digit_o = NEG2;
            3'b101, 3'b110: digit_o = NEG1;
            default:        digit_o = ZERO;
        endcase
    end

endmodule

// File: rtl/mult_booth_r4_seq.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, fixed latency WIDTH/2+1.
// Optional macro MULT_ACC_EN adds an acc_en input for multiply-accumulate into y.
module mult_booth_r4_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    input  logic               init,
`ifdef MULT_ACC_EN
    input  logic               acc_en,
`endif
    output logic [2*WIDTH-1:0] y,
    output logic               busy,
    output logic               done
);

    localparam int ITER = iter_f(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int CW   = $clog2(ITER + 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  y_q;
    logic                busy_q;
    logic                done_q;
    logic                acc_en_q;

    logic [EW:0]         bsh_q;
    logic [AW-1:0]       asl_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       acc_d;
    logic [AW-1:0]       term;

    logic [EW-1:0]       a_ext;
    logic [EW-1:0]       b_ext;
    logic                start;
    logic                last;
    digit_e              digit;

    assign a_ext = sgn ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = sgn ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign start = init && (state_q != CALC);
    assign last  = (cnt_q == CW'(ITER - 1));

    booth_r4_enc u_enc (
        .trip_i  (bsh_q[2:0]),
        .digit_o (digit)
    );

    always_comb begin
        term = '0;
        unique case (digit)
            ZERO:    term = '0;
            POS1:    term = asl_q;
            POS2:    term = asl_q << 1;
            NEG1:    term = -asl_q;
            NEG2:    term = -(asl_q << 1);
            default: term = '0;
        endcase
        acc_d = acc_q + term;
    end

    // Datapath: bsh_q exposes the next triplet at [2:0] (b[-1]=0 appended),
    // asl_q holds a << 2i in accumulator width.
    always_ff @(posedge clk) begin
        if (start) begin
            bsh_q <= {b_ext, 1'b0};
            asl_q <= {{WIDTH{a_ext[EW-1]}}, a_ext};
            acc_q <= '0;
        end else if (state_q == CALC) begin
            bsh_q <= bsh_q >> 2;
            asl_q <= asl_q << 2;
            acc_q <= acc_d;
        end
    end

    // Control FSM; the last CALC cycle folds its own partial product into y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (init) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
`ifdef MULT_ACC_EN
                        acc_en_q <= acc_en;
`else
                        acc_en_q <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        y_q     <= acc_en_q ? (y_q + acc_d[2*WIDTH-1:0])
                                            : acc_d[2*WIDTH-1:0];
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_booth_r4_seq.sv
// Self-checking bench for mult_booth_r4_seq (WIDTH=8): directed corner cases,
// back-to-back and reset-abort scenarios, then randomized operations vs. a product model.
module tb_mult_booth_r4_seq;

    localparam int W    = 8;
    localparam int ITER = W / 2 + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic           init;
    logic           acc_en;
    logic [2*W-1:0] y;
    logic           busy;
    logic           done;

    int             checks   = 0;
    int             failures = 0;
    logic [2*W-1:0] y_ref;

    always #5 clk = ~clk;

    mult_booth_r4_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .sgn    (sgn),
        .init   (init),
`ifdef MULT_ACC_EN
        .acc_en (acc_en),
`endif
        .y      (y),
        .busy   (busy),
        .done   (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] z,
                                                input logic s);
        longint p;
        if (s) p = longint'($signed(x)) * longint'($signed(z));
        else   p = longint'(x) * longint'(z);
        return p[2*W-1:0];
    endfunction

    // Launches one op; hold keeps init high through CALC, b2b starts from within the DONE cycle.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                         input logic xacc, input bit hold, input bit b2b, input string tag);
        logic [2*W-1:0] p;
        int n;
        bit seen;
        if (!b2b) @(negedge clk);
        a = xa; b = xb; sgn = xs; acc_en = xacc; init = 1'b1;
        p = ref_prod(xa, xb, xs);
`ifdef MULT_ACC_EN
        y_ref = xacc ? (y_ref + p) : p;
`else
        y_ref = p;
`endif
        @(posedge clk); #1;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_nodone"}, done, 0);
        if (!hold) init = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 4 * ITER) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                a = W'($urandom); b = W'($urandom); sgn = 1'($urandom); acc_en = 1'($urandom);
            end
        end
        init = 1'b0;
        check({tag, "_latency"}, n, ITER);
        check({tag, "_y"}, y, y_ref);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int nd;
        reset = 1'b1; init = 1'b0; a = '0; b = '0; sgn = 1'b0; acc_en = 1'b0; y_ref = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        do_op(8'hF5, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0, "s_m11_m5");
        check("s_m11_m5_const", y, 16'h0037);
        idle_check("after1");
        do_op(8'hF5, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, "s_m11_5");
        check("s_m11_5_const", y, 16'hFFC9);
        do_op(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, "s_min_min");
        check("s_min_min_const", y, 16'h4000);
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "u_255_255");
        check("u_255_255_const", y, 16'hFE01);
        do_op(8'h80, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, "u_80_2");
        check("u_80_2_const", y, 16'h0100);
        do_op(8'h9C, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "s_x_0");
        check("s_x_0_const", y, 16'h0000);

        do_op(8'd37, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, "hold");
        check("hold_const", y, 16'd7400);
        idle_check("after_hold");
        do_op(8'h6B, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b0, "pre_b2b");
        do_op(8'hFD, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, "b2b");
        check("b2b_const", y, 16'hFFEB);

`ifdef MULT_ACC_EN
        do_op(8'hF5, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0, "mac_first");
        do_op(8'hF5, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, "mac_second");
        check("mac_zero", y, 16'h0000);
`endif

        @(negedge clk);
        a = 8'h33; b = 8'h21; sgn = 1'b0; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_y", y, 0);
        check("abort_done", done, 0);
        y_ref = '0;
        @(negedge clk);
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", nd, 0);
        do_op(8'h33, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rnd");
        end
        idle_check("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
